int_ctrl: RTL and testbench

- Parametrised, multi-source machine-mode interrupt controller for the pipelined core.
- Accepts NUM_IRQ sources, each configurable as level or edge, and latches a pending bit per source.
- Arbitrates by fixed priority, then runs a CSR save sequence (mepc, mcause, mstatus) while holding the pipeline, and redirects fetch to the trap vector.
- Also handles mret: restores mstatus and redirects fetch to mepc.

---
 rtl/int_ctrl_pkg.sv | 21 ++
 rtl/int_ctrl_irq_pending.sv | 46 ++++
 rtl/int_ctrl.sv | 138 +++++++++++++
 tb/tb_int_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: CSR addresses, mstatus bit positions and FSM states shared by the interrupt controller.
package int_ctrl_pkg;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [2:0] {
        IDLE,
        SV_MEPC,
        SV_MCAUSE,
        SV_MSTATUS,
        ASSERT,
        MR_MSTATUS,
        MR_ASSERT
    } state_e;

endpackage

// File: rtl/int_ctrl_irq_pending.sv
// irq_pending: per-source edge/level capture into pending bits plus masked lowest-index-first encoder.
module irq_pending #(
    parameter int                 NUM_IRQ  = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0,
    parameter int                 ID_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               global_int_en,
    input  logic               clr,
    input  logic [ID_W-1:0]    clr_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               req,
    output logic [ID_W-1:0]    id
);

    logic [NUM_IRQ-1:0] pending_q, pending_d, prev_q, masked;

    always_comb begin
        masked = pending_q & irq_en;
        req    = |masked & global_int_en;
        id     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (masked[i]) id = ID_W'(i);
        // a fresh edge in the clearing cycle must survive, so the set term is ORed last
        for (int i = 0; i < NUM_IRQ; i++)
            pending_d[i] = IRQ_EDGE[i]
                ? (pending_q[i] & ~(clr && clr_id == ID_W'(i))) | (irq[i] & ~prev_q[i])
                : irq[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            prev_q    <= '0;
        end else begin
            pending_q <= pending_d;
            prev_q    <= irq;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: machine-mode interrupt controller; saves mepc/mcause/mstatus, redirects fetch, and handles mret.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ  = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0,
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 32,
    parameter int                 CSR_AW   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               global_int_en,
    input  logic               mret,
    input  logic [ADDR_W-1:0]  inst_addr,
    input  logic               jump_flag,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic [DATA_W-1:0]  csr_mtvec,
    input  logic [DATA_W-1:0]  csr_mepc,
    input  logic [DATA_W-1:0]  csr_mstatus,
    output logic               hold_flag_int,
    output logic               csr_we,
    output logic [CSR_AW-1:0]  csr_waddr,
    output logic [DATA_W-1:0]  csr_wdata,
    output logic               int_assert,
    output logic [ADDR_W-1:0]  int_addr,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam int ID_W = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d, win_id;
    logic [ADDR_W-1:0] pc_q, pc_d, vec_base;
    logic [DATA_W-1:0] trap_mst, mret_mst;
    logic              req;

    irq_pending #(
        .NUM_IRQ (NUM_IRQ),
        .IRQ_EDGE(IRQ_EDGE),
        .ID_W    (ID_W)
    ) u_pending (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .irq_en       (irq_en),
        .global_int_en(global_int_en),
        .clr          (state_q == ASSERT),
        .clr_id       (id_q),
        .pending      (irq_pending),
        .req          (req),
        .id           (win_id)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (mret) begin
                    state_d = MR_MSTATUS;
                end else if (req) begin
                    state_d = SV_MEPC;
                    id_d    = win_id;
                    pc_d    = jump_flag ? jump_addr : inst_addr;
                end
            end
            SV_MEPC:    state_d = SV_MCAUSE;
            SV_MCAUSE:  state_d = SV_MSTATUS;
            SV_MSTATUS: state_d = ASSERT;
            MR_MSTATUS: state_d = MR_ASSERT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        trap_mst               = csr_mstatus;
        trap_mst[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
        trap_mst[MSTATUS_MIE]  = 1'b0;
        mret_mst               = csr_mstatus;
        mret_mst[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
        mret_mst[MSTATUS_MPIE] = 1'b1;
        vec_base               = {csr_mtvec[ADDR_W-1:2], 2'b00};
        hold_flag_int          = state_q != IDLE;
        csr_we                 = 1'b0;
        csr_waddr              = '0;
        csr_wdata              = '0;
        int_assert             = 1'b0;
        int_addr               = '0;
        case (state_q)
            SV_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MEPC);
                csr_wdata = DATA_W'(pc_q);
            end
            SV_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MCAUSE);
                csr_wdata = {1'b1, (DATA_W-1)'(id_q)};
            end
            SV_MSTATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MSTATUS);
                csr_wdata = trap_mst;
            end
            ASSERT: begin
                int_assert = 1'b1;
                int_addr   = vec_base + (csr_mtvec[1:0] == 2'b01 ? ADDR_W'({id_q, 2'b00}) : '0);
            end
            MR_MSTATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MSTATUS);
                csr_wdata = mret_mst;
            end
            MR_ASSERT: begin
                int_assert = 1'b1;
                int_addr   = csr_mepc[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed and random stimulus against an event-queue model of the trap/mret sequences.
module tb_int_ctrl;

    localparam logic [7:0] EDGE = 8'h4C;

    typedef struct {
        int          kind;
        int          id;
        logic [31:0] pc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst, gie, mret, jump_flag;
    logic [7:0]  irq, irq_en;
    logic [31:0] inst_addr, jump_addr, mtvec, mepc, mstatus;
    logic        hold_flag_int, csr_we, int_assert;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, int_addr;
    logic [7:0]  irq_pending;

    int total = 0;
    int bad = 0;

    ev_t         q[$];
    logic [7:0]  pend_m, prev_m;
    logic [31:0] w_mepc, w_mcause, w_mst;
    logic [31:0] asserts[$];
    logic [11:0] waddrs[$];

    always #5 clk = ~clk;

    int_ctrl #(
        .NUM_IRQ (8),
        .IRQ_EDGE(EDGE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .irq_en       (irq_en),
        .global_int_en(gie),
        .mret         (mret),
        .inst_addr    (inst_addr),
        .jump_flag    (jump_flag),
        .jump_addr    (jump_addr),
        .csr_mtvec    (mtvec),
        .csr_mepc     (mepc),
        .csr_mstatus  (mstatus),
        .hold_flag_int(hold_flag_int),
        .csr_we       (csr_we),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .int_assert   (int_assert),
        .int_addr     (int_addr),
        .irq_pending  (irq_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        ev_t         cur;
        int          win;
        logic        e_we, e_ia;
        logic [11:0] e_wa;
        logic [31:0] e_wd, e_ia_addr, m;
        @(posedge clk);
        if (rst) begin
            q.delete();
            pend_m = '0;
            prev_m = '0;
        end else begin
            win = -1;
            for (int i = 7; i >= 0; i--)
                if (pend_m[i] && irq_en[i]) win = i;
            cur.kind = 0;
            cur.id   = 0;
            cur.pc   = '0;
            if (q.size() != 0) begin
                cur = q.pop_front();
            end else if (mret) begin
                q.push_back('{5, 0, 32'h0});
                q.push_back('{6, 0, 32'h0});
            end else if (gie && win >= 0) begin
                for (int k = 1; k <= 4; k++)
                    q.push_back('{k, win, jump_flag ? jump_addr : inst_addr});
            end
            for (int i = 0; i < 8; i++)
                pend_m[i] = EDGE[i]
                    ? ((pend_m[i] && !(cur.kind == 4 && cur.id == i)) || (irq[i] && !prev_m[i]))
                    : irq[i];
            prev_m = irq;
        end
        #1;
        e_we = 0; e_wa = '0; e_wd = '0; e_ia = 0; e_ia_addr = '0;
        if (q.size() != 0) begin
            cur = q[0];
            m = mstatus;
            case (cur.kind)
                1: begin e_we = 1; e_wa = 12'h341; e_wd = cur.pc; end
                2: begin e_we = 1; e_wa = 12'h342; e_wd = 32'h8000_0000 | cur.id; end
                3: begin m[7] = mstatus[3]; m[3] = 1'b0; e_we = 1; e_wa = 12'h300; e_wd = m; end
                4: begin
                    e_ia = 1;
                    e_ia_addr = (mtvec & ~32'h3) + ((mtvec[1:0] == 2'b01) ? 32'(cur.id * 4) : 32'h0);
                end
                5: begin m[3] = mstatus[7]; m[7] = 1'b1; e_we = 1; e_wa = 12'h300; e_wd = m; end
                default: begin e_ia = 1; e_ia_addr = mepc; end
            endcase
        end
        chk("hold", 32'(hold_flag_int), 32'(q.size() != 0));
        chk("we", 32'(csr_we), 32'(e_we));
        chk("waddr", 32'(csr_waddr), 32'(e_wa));
        chk("wdata", csr_wdata, e_wd);
        chk("int_assert", 32'(int_assert), 32'(e_ia));
        chk("int_addr", int_addr, e_ia_addr);
        chk("pending", 32'(irq_pending), 32'(pend_m));
        if (csr_we) begin
            waddrs.push_back(csr_waddr);
            if (csr_waddr == 12'h341) w_mepc = csr_wdata;
            if (csr_waddr == 12'h342) w_mcause = csr_wdata;
            if (csr_waddr == 12'h300) w_mst = csr_wdata;
        end
        if (int_assert) asserts.push_back(int_addr);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (hold_flag_int && k < 20) begin
            step();
            k++;
        end
        chk("idle_timeout", 32'(hold_flag_int), 32'h0);
    endtask

    function automatic logic [31:0] nth(input int i);
        return (asserts.size() > i) ? asserts[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int          k;
        logic [31:0] r;
        rst = 1; irq = '0; irq_en = '0; gie = 0; mret = 0; jump_flag = 0;
        inst_addr = '0; jump_addr = '0; mtvec = '0; mepc = '0; mstatus = '0;
        pend_m = '0; prev_m = '0;
        run(2);
        rst = 0;
        chk("rst_hold", 32'(hold_flag_int), 32'h0);

        irq_en = 8'hFF; gie = 1; inst_addr = 32'h40; mtvec = 32'h100; mstatus = 32'h8;
        asserts.delete();
        irq = 8'h20;
        step();
        chk("lvl_t0_hold", 32'(hold_flag_int), 32'h0);
        run(4);
        chk("lvl_t4_assert", 32'(int_assert), 32'h1);
        chk("lvl_addr", int_addr, 32'h100);
        chk("lvl_mepc", w_mepc, 32'h40);
        chk("lvl_mcause", w_mcause, 32'h8000_0005);
        chk("lvl_mstatus", w_mst, 32'h80);
        irq = '0;
        wait_idle();

        mtvec = 32'h201; asserts.delete();
        irq = 8'h44;
        run(14);
        chk("vec_count", asserts.size(), 2);
        chk("vec_first", nth(0), 32'h208);
        chk("vec_second", nth(1), 32'h218);
        chk("vec_pend_clr", 32'(irq_pending & 8'h44), 32'h0);
        irq = '0;
        wait_idle();

        jump_flag = 1; jump_addr = 32'h80; inst_addr = 32'h40; irq = 8'h01;
        run(3);
        jump_flag = 0; irq = '0;
        wait_idle();
        chk("jmp_mepc", w_mepc, 32'h80);

        mstatus = 32'h80; mepc = 32'h44; asserts.delete();
        mret = 1;
        step();
        mret = 0;
        run(2);
        chk("mret_mstatus", w_mst, 32'h88);
        chk("mret_addr", nth(0), 32'h44);
        wait_idle();

        mtvec = 32'h100; asserts.delete(); waddrs.delete();
        irq = 8'h01;
        step();
        mret = 1;
        step();
        mret = 0;
        run(3);
        irq = '0;
        wait_idle();
        chk("mret_irq_first_wr", 32'((waddrs.size() > 0) ? waddrs[0] : 12'hFFF), 32'h300);
        chk("mret_irq_trap_wr", 32'((waddrs.size() > 1) ? waddrs[1] : 12'hFFF), 32'h341);
        chk("mret_irq_a0", nth(0), 32'h44);
        chk("mret_irq_a1", nth(1), 32'h100);

        mtvec = 32'h201; irq_en = 8'hF7; gie = 1;
        irq = 8'h08;
        run(4);
        chk("mask_en_hold", 32'(hold_flag_int), 32'h0);
        chk("mask_en_pend", 32'(irq_pending[3]), 32'h1);
        irq_en = 8'hFF; gie = 0;
        run(3);
        chk("mask_gie_hold", 32'(hold_flag_int), 32'h0);
        asserts.delete();
        gie = 1;
        run(7);
        chk("mask_fire", nth(0), 32'h20C);
        chk("mask_pend_clr", 32'(irq_pending[3]), 32'h0);
        irq = '0;
        wait_idle();

        mtvec = 32'h100; irq = 8'h20;
        k = 0;
        while (!(csr_we && csr_waddr == 12'h342) && k < 10) begin
            step();
            k++;
        end
        chk("rst_reach_mcause", 32'(csr_waddr), 32'h342);
        asserts.delete();
        rst = 1;
        step();
        rst = 0;
        chk("rst_hold0", 32'(hold_flag_int), 32'h0);
        chk("rst_we0", 32'(csr_we), 32'h0);
        chk("rst_ia0", 32'(int_assert), 32'h0);
        chk("rst_pend0", 32'(irq_pending), 32'h0);
        irq = '0;
        run(3);
        chk("rst_no_assert", asserts.size(), 0);

        repeat (500) begin
            if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
            irq_en = 8'($urandom);
            gie = $urandom_range(0, 3) != 0;
            mret = $urandom_range(0, 9) == 0;
            jump_flag = $urandom_range(0, 1) == 1;
            r = $urandom; jump_addr = r & ~32'h3;
            r = $urandom; inst_addr = r & ~32'h3;
            r = $urandom; mtvec = (r & ~32'h3) | 32'($urandom_range(0, 1));
            mstatus = $urandom;
            mepc = $urandom;
            rst = $urandom_range(0, 99) == 0;
            step();
        end
        rst = 0; mret = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
